ysyx_22050710_dsram_responder: RTL and testbench



---
 rtl/ysyx_22050710_dsram_responder.sv | 147 ++++++++++++++
 tb/tb_ysyx_22050710_dsram_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_dsram_responder.sv
// ============================================================================
// Module   : ysyx_22050710_dsram_responder
// Purpose  : Memory-side end of the data SRAM request/response interface.
//            Byte-masked writes complete on addr_ok; reads are queued in order
//            and answered with a data_ok pulse LATENCY cycles after reaching
//            the head of the queue.
// Option   : define YSYX_22050710_DSRAM_STALL_EN to add LFSR-driven
//            pseudo-random addr_ok stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050710_dsram_responder #(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_DATA_WD  = 64,
  parameter int SRAM_WMASK_WD = 8,
  parameter int MEM_DEPTH     = 1024,
  parameter int LATENCY       = 2,
  parameter int QUEUE_DEPTH   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
  input  logic                     i_data_sram_ren,
  input  logic                     i_data_sram_wen,
  input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wmask,
  input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
  output logic                     o_data_sram_addr_ok,
  output logic                     o_data_sram_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int HC_W  = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] c_QFULL    = CNT_W'(QUEUE_DEPTH);
  localparam logic [HC_W-1:0]  c_LAT      = HC_W'(LATENCY);
  localparam logic [HC_W-1:0]  c_HC_ONE   = HC_W'(1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  logic [SRAM_DATA_WD-1:0] r_mem   [0:MEM_DEPTH-1];
  logic [SRAM_DATA_WD-1:0] r_qdata [0:QUEUE_DEPTH-1];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic [HC_W-1:0]         r_hcnt;
  logic [SRAM_DATA_WD-1:0] r_rdata_hold;

  logic [IDX_W-1:0] w_idx;
  logic             w_unused_addr;
  logic             w_stall;
  logic             w_addr_ok;
  logic             w_wr;
  logic             w_push;
  logic             w_pop;

  // Word-aligned index; upper bits alias, byte offset is carried by wmask.
  assign w_idx         = i_data_sram_addr[IDX_W+2:3];
  assign w_unused_addr = ^{i_data_sram_addr[SRAM_ADDR_WD-1:IDX_W+3],
                           i_data_sram_addr[2:0]};

`ifdef YSYX_22050710_DSRAM_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Fullness is judged on the pre-pop count, so a same-cycle pop frees nothing.
  always_comb begin
    w_addr_ok = 1'b0;
    if (!i_rst_n || w_stall) begin
      w_addr_ok = 1'b0;
    end else if (i_data_sram_wen) begin
      w_addr_ok = 1'b1;
    end else if (i_data_sram_ren) begin
      w_addr_ok = (r_count != c_QFULL);
    end
  end

  assign w_wr   = i_data_sram_wen & w_addr_ok;
  assign w_push = i_data_sram_ren & ~i_data_sram_wen & w_addr_ok;
  assign w_pop  = (r_count != '0) && (r_hcnt == c_LAT);

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SRAM_WMASK_WD; i++) begin
      if (w_wr && i_data_sram_wmask[i]) begin
        r_mem[w_idx][i*8 +: 8] <= i_data_sram_wdata[i*8 +: 8];
      end
    end
  end

  // Read data is captured at accept so later writes cannot disturb it.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_qdata[r_wptr] <= r_mem[w_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_hcnt       <= '0;
      r_rdata_hold <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr       <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
        r_rdata_hold <= r_qdata[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Whatever sits at the head next cycle starts its wait at 1.
      if (w_pop || (r_count == '0)) begin
        r_hcnt <= c_HC_ONE;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  assign o_data_sram_addr_ok = w_addr_ok;
  assign o_data_sram_data_ok = w_pop;
  assign o_data_sram_rdata   = w_pop ? r_qdata[r_rptr] : r_rdata_hold;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_dsram_responder.sv
// ============================================================================
// Module   : tb_ysyx_22050710_dsram_responder
// Purpose  : Self-checking bench for the data SRAM responder against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050710_dsram_responder;

  localparam int LAT = 2;
  localparam int QD  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [7:0]  wmask;
  logic [63:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  ysyx_22050710_dsram_responder #(
    .SRAM_ADDR_WD (32),
    .SRAM_DATA_WD (64),
    .SRAM_WMASK_WD(8),
    .MEM_DEPTH    (1024),
    .LATENCY      (LAT),
    .QUEUE_DEPTH  (QD)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_data_sram_addr   (addr),
    .i_data_sram_ren    (ren),
    .i_data_sram_wen    (wen),
    .i_data_sram_wmask  (wmask),
    .i_data_sram_wdata  (wdata),
    .o_data_sram_addr_ok(addr_ok),
    .o_data_sram_data_ok(data_ok),
    .o_data_sram_rdata  (rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word memory, outstanding reads with their due cycle.
  logic [63:0] mm [0:1023];
  logic [63:0] pend_dat [$];
  int          pend_due [$];
  int          dok_at   [$];
  logic [63:0] m_last;
  int          cyc;

  logic        obs_aok;
  logic        obs_dok;
  logic [63:0] obs_rd;
  int          obs_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, advance model, move on.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [7:0] m, input logic [63:0] d);
    logic        e_aok;
    logic        e_dok;
    logic [63:0] e_rd;
    int          idx;
    int          due;
    ren = r; wen = w; addr = a; wmask = m; wdata = d;
    #1;
    idx   = int'(a[12:3]);
    e_aok = w ? 1'b1 : (r ? (pend_dat.size() < QD) : 1'b0);
    e_dok = (pend_due.size() > 0) && (pend_due[0] == cyc);
    e_rd  = e_dok ? pend_dat[0] : m_last;
    chk("addr_ok", addr_ok, e_aok);
    chk("data_ok", data_ok, e_dok);
    chk("rdata", rdata, e_rd);
    obs_aok = addr_ok; obs_dok = data_ok; obs_rd = rdata; obs_cyc = cyc;
    if (data_ok) dok_at.push_back(cyc);
    if (e_dok) begin
      m_last = pend_dat.pop_front();
      void'(pend_due.pop_front());
    end
    if (w && e_aok) begin
      for (int i = 0; i < 8; i++)
        if (m[i]) mm[idx][i*8 +: 8] = d[i*8 +: 8];
    end else if (r && e_aok) begin
      due = cyc + LAT;
      if (pend_due.size() > 0 && pend_due[$] + LAT > due) due = pend_due[$] + LAT;
      pend_dat.push_back(mm[idx]);
      pend_due.push_back(due);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
  endtask

  task automatic wait_dok(input string tag, input int acc, input logic [63:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
      if (obs_dok) got = 1'b1;
    end
    chk({tag, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_lat"}, 64'(obs_cyc - acc), 64'(LAT));
      chk({tag, "_data"}, obs_rd, exp);
    end
  endtask

  initial begin
    int          acc;
    int          a_cyc;
    int          c_acc;
    logic [63:0] oldv;
    logic [31:0] ra;
    int          op;

    rst_n = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wmask = '0; wdata = '0;
    m_last = '0; cyc = 0;
    @(negedge clk);
    @(negedge clk);
    ren = 1'b1; addr = 32'h8000_0010;
    #1;
    chk("rst_addr_ok", addr_ok, 1'b0);
    chk("rst_data_ok", data_ok, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initialise words 0..7 so every later read has a defined value.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 32'h8000_0000 + 32'(i * 8), 8'hFF, {$urandom, $urandom});

    // 1: full write then read
    step(1'b0, 1'b1, 32'h8000_0010, 8'hFF, 64'h1122334455667788);
    acc = cyc;
    step(1'b1, 1'b0, 32'h8000_0010, 8'h00, 64'h0);
    wait_dok("t1", acc, 64'h1122334455667788);

    // 2: partial write keeps upper lanes
    step(1'b0, 1'b1, 32'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    acc = cyc;
    step(1'b1, 1'b0, 32'h8000_0010, 8'h00, 64'h0);
    wait_dok("t2", acc, 64'h11223344_BBBBBBBB);

    // 3: three reads against a two-deep queue
    dok_at.delete();
    a_cyc = cyc;
    step(1'b1, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
    step(1'b1, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
    c_acc = -1;
    for (int k = 0; k < 6 && c_acc < 0; k++) begin
      step(1'b1, 1'b0, 32'h8000_0018, 8'h00, 64'h0);
      if (obs_aok) c_acc = obs_cyc;
    end
    chk("t3_third_accept", 64'(c_acc - a_cyc), 64'd3);
    idle(8);
    chk("t3_pulses", 64'(dok_at.size()), 64'd3);
    if (dok_at.size() == 3) begin
      chk("t3_first", 64'(dok_at[0] - a_cyc), 64'(LAT));
      chk("t3_gap1", 64'(dok_at[1] - dok_at[0]), 64'(LAT));
      chk("t3_gap2", 64'(dok_at[2] - dok_at[1]), 64'(LAT));
    end

    // 4: read data frozen at accept
    oldv = mm[5];
    acc  = cyc;
    step(1'b1, 1'b0, 32'h8000_0028, 8'h00, 64'h0);
    step(1'b0, 1'b1, 32'h8000_0028, 8'hFF, 64'h5);
    wait_dok("t4_old", acc, oldv);
    acc = cyc;
    step(1'b1, 1'b0, 32'h8000_0028, 8'h00, 64'h0);
    wait_dok("t4_new", acc, 64'h5);

    // 5: ren and wen together is a write only
    dok_at.delete();
    step(1'b1, 1'b1, 32'h8000_0020, 8'hFF, 64'h9);
    idle(4);
    chk("t5_no_dok", 64'(dok_at.size()), 64'd0);
    acc = cyc;
    step(1'b1, 1'b0, 32'h8000_0020, 8'h00, 64'h0);
    wait_dok("t5", acc, 64'h9);

    // 6: asynchronous reset with two reads outstanding
    step(1'b1, 1'b0, 32'h8000_0030, 8'h00, 64'h0);
    step(1'b1, 1'b0, 32'h8000_0038, 8'h00, 64'h0);
    ren = 1'b0;
    #1;
    chk("t6_pre_dok", data_ok, 1'b1);
    ren = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dok", data_ok, 1'b0);
    chk("t6_rst_rdata", rdata, 64'h0);
    chk("t6_rst_aok", addr_ok, 1'b0);
    pend_dat.delete(); pend_due.delete(); m_last = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = cyc + 3;
    acc = cyc;
    step(1'b1, 1'b0, 32'h8000_0030, 8'h00, 64'h0);
    wait_dok("t6_after", acc, mm[6]);

    // Randomised traffic over aliased addresses of words 0..7
    for (int n = 0; n < 300; n++) begin
      ra       = $urandom;
      ra[12:3] = {7'b0, 3'($urandom_range(0, 7))};
      op       = $urandom_range(0, 9);
      if (op < 4)      step(1'b1, 1'b0, ra, 8'h00, 64'h0);
      else if (op < 6) step(1'b0, 1'b1, ra, 8'($urandom), {$urandom, $urandom});
      else if (op < 7) step(1'b1, 1'b1, ra, 8'($urandom), {$urandom, $urandom});
      else             idle(1);
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
